// File: rtl/clk_gate_ce.sv
// Glitch-free clock gate with clock enable, scan bypass and activity counters.
// Define CLK_GATE_FPGA_PRIM_EN to use the vendor global-buffer-with-CE primitive.
module clk_gate_ce #(
  parameter int unsigned SYNC_STAGES = 0,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 test_en,
  input  logic                 cnt_clr,
  output logic                 gclk,
  output logic                 en_q,
  output logic [CNT_WIDTH-1:0] active_cycles,
  output logic [CNT_WIDTH-1:0] total_cycles
);

  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  logic                 ce_s;
  logic                 en_req;
  logic                 en_eff;
  logic                 en_q_q;
  logic [CNT_WIDTH-1:0] active_q;
  logic [CNT_WIDTH-1:0] total_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign ce_s = ce;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= ce;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign ce_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign en_req = ce_s | test_en;

`ifdef CLK_GATE_FPGA_PRIM_EN
  logic en_neg_q;

  // Falling-edge copy of en_req matches what the primitive's internal CE latch holds.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_neg_q <= 1'b0;
    end else begin
      en_neg_q <= en_req;
    end
  end

  BUFGCE u_bufgce (
    .I  (clk),
    .CE (en_req & rst_n),
    .O  (gclk)
  );

  assign en_eff = en_neg_q;
`else
  logic en_lat;

  // Transparent in the low phase only, so en_req cannot disturb an in-flight high phase.
  always_latch begin
    if (!rst_n) begin
      en_lat = 1'b0;
    end else if (!clk) begin
      en_lat = en_req;
    end
  end

  assign gclk   = clk & en_lat;
  assign en_eff = en_lat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q_q   <= 1'b0;
      active_q <= '0;
      total_q  <= '0;
    end else begin
      en_q_q <= en_eff;
      if (cnt_clr) begin
        active_q <= '0;
        total_q  <= '0;
      end else begin
        if (total_q != CntMax) begin
          total_q <= total_q + 1'b1;
        end
        if (en_eff && (active_q != CntMax)) begin
          active_q <= active_q + 1'b1;
        end
      end
    end
  end

  assign en_q          = en_q_q;
  assign active_cycles = active_q;
  assign total_cycles  = total_q;

endmodule

// File: tb/tb_clk_gate_ce.sv
// Directed bench for clk_gate_ce: three instances share stimulus (sync 0, sync 2, 8-bit counters).
module tb_clk_gate_ce;

  logic clk;
  logic rst_n;
  logic ce;
  logic test_en;
  logic cnt_clr;

  logic        g0, e0, g2, e2, g8, e8;
  logic [31:0] a0, t0, a2, t2;
  logic [7:0]  a8, t8;

  int total = 0;
  int bad   = 0;
  int pc0   = 0;
  int pc2   = 0;
  int pc8   = 0;

  clk_gate_ce #(.SYNC_STAGES(0), .CNT_WIDTH(32)) u_d0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .test_en(test_en), .cnt_clr(cnt_clr),
    .gclk(g0), .en_q(e0), .active_cycles(a0), .total_cycles(t0)
  );

  clk_gate_ce #(.SYNC_STAGES(2), .CNT_WIDTH(32)) u_d2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .test_en(test_en), .cnt_clr(cnt_clr),
    .gclk(g2), .en_q(e2), .active_cycles(a2), .total_cycles(t2)
  );

  clk_gate_ce #(.SYNC_STAGES(0), .CNT_WIDTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .test_en(test_en), .cnt_clr(cnt_clr),
    .gclk(g8), .en_q(e8), .active_cycles(a8), .total_cycles(t8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge g0) pc0++;
  always @(posedge g2) pc2++;
  always @(posedge g8) pc8++;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic test_reset();
    int p0;
    total++; if ({g0, e0, g2, e2, g8, e8} !== 6'b0) begin
      bad++; $display("FAIL reset_outs got=%b exp=000000", {g0, e0, g2, e2, g8, e8});
    end
    total++; if ((a0 | t0 | a2 | t2) !== 32'd0 || (a8 | t8) !== 8'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0", a0, t0, t8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pc0;
    repeat (10) @(negedge clk);
    total++; if (t0 !== 32'd10) begin bad++; $display("FAIL idle_total got=%0d exp=10", t0); end
    total++; if (a0 !== 32'd0) begin bad++; $display("FAIL idle_active got=%0d exp=0", a0); end
    total++; if (e0 !== 1'b0) begin bad++; $display("FAIL idle_en_q got=%b exp=0", e0); end
    total++; if (pc0 - p0 !== 0) begin bad++; $display("FAIL idle_pulses got=%0d exp=0", pc0 - p0); end
    total++; if (t8 !== 8'd10) begin bad++; $display("FAIL idle_total8 got=%0d exp=10", t8); end
  endtask

  task automatic test_ce_window();
    int  p0, p2;
    logic x0, x2;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    p0 = pc0;
    p2 = pc2;
    for (int i = 1; i <= 10; i++) begin
      ce = (i >= 3 && i <= 7);
      @(negedge clk);
      x0 = (i >= 3 && i <= 7);
      x2 = (i >= 5 && i <= 9);
      total++; if (e0 !== x0) begin bad++; $display("FAIL win_en_q0 edge=%0d got=%b exp=%b", i, e0, x0); end
      total++; if (e2 !== x2) begin bad++; $display("FAIL win_en_q2 edge=%0d got=%b exp=%b", i, e2, x2); end
    end
    total++; if (a0 !== 32'd5) begin bad++; $display("FAIL win_active0 got=%0d exp=5", a0); end
    total++; if (t0 !== 32'd10) begin bad++; $display("FAIL win_total0 got=%0d exp=10", t0); end
    total++; if (pc0 - p0 !== 5) begin bad++; $display("FAIL win_pulses0 got=%0d exp=5", pc0 - p0); end
    total++; if (a2 !== 32'd5) begin bad++; $display("FAIL win_active2 got=%0d exp=5", a2); end
    total++; if (pc2 - p2 !== 5) begin bad++; $display("FAIL win_pulses2 got=%0d exp=5", pc2 - p2); end
  endtask

  task automatic test_glitch();
    @(posedge clk);
    #1 ce = 1'b1;
    #1 total++; if (g0 !== 1'b0) begin bad++; $display("FAIL glitch_rise_a got=%b exp=0", g0); end
    ce = 1'b0;
    #1 total++; if (g0 !== 1'b0) begin bad++; $display("FAIL glitch_rise_b got=%b exp=0", g0); end
    ce = 1'b1;
    #1 total++; if (g0 !== 1'b0) begin bad++; $display("FAIL glitch_rise_c got=%b exp=0", g0); end
    @(posedge clk);
    #1 total++; if (g0 !== 1'b1) begin bad++; $display("FAIL glitch_next_on got=%b exp=1", g0); end
    ce = 1'b0;
    #1 total++; if (g0 !== 1'b1) begin bad++; $display("FAIL glitch_hold_a got=%b exp=1", g0); end
    ce = 1'b1;
    #1 ce = 1'b0;
    #1 total++; if (g0 !== 1'b1) begin bad++; $display("FAIL glitch_hold_b got=%b exp=1", g0); end
    @(posedge clk);
    #1 total++; if (g0 !== 1'b0) begin bad++; $display("FAIL glitch_next_off got=%b exp=0", g0); end
  endtask

  task automatic test_sync2();
    int   p2;
    logic x2;
    @(negedge clk);
    ce = 1'b0;
    repeat (3) @(negedge clk);
    p2 = pc2;
    for (int i = 1; i <= 8; i++) begin
      ce = (i >= 4);
      @(negedge clk);
      x2 = (i >= 6);
      total++; if (e2 !== x2) begin bad++; $display("FAIL sync2_en_q edge=%0d got=%b exp=%b", i, e2, x2); end
    end
    total++; if (pc2 - p2 !== 3) begin bad++; $display("FAIL sync2_pulses got=%0d exp=3", pc2 - p2); end
    ce = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_scan();
    int p0, p2;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    p0 = pc0;
    p2 = pc2;
    test_en = 1'b1;
    repeat (8) @(negedge clk);
    total++; if (a0 !== 32'd8) begin bad++; $display("FAIL scan_active0 got=%0d exp=8", a0); end
    total++; if (t0 !== 32'd8) begin bad++; $display("FAIL scan_total0 got=%0d exp=8", t0); end
    total++; if (a2 !== 32'd8) begin bad++; $display("FAIL scan_active2 got=%0d exp=8", a2); end
    total++; if (pc0 - p0 !== 8) begin bad++; $display("FAIL scan_pulses0 got=%0d exp=8", pc0 - p0); end
    total++; if (pc2 - p2 !== 8) begin bad++; $display("FAIL scan_pulses2 got=%0d exp=8", pc2 - p2); end
    cnt_clr = 1'b1;
    @(negedge clk);
    total++; if (a0 !== 32'd0 || t0 !== 32'd0) begin
      bad++; $display("FAIL clr_zero got=%0d/%0d exp=0/0", a0, t0);
    end
    cnt_clr = 1'b0;
    test_en = 1'b0;
    @(negedge clk);
    total++; if (a0 !== 32'd0 || t0 !== 32'd1) begin
      bad++; $display("FAIL clr_after got=%0d/%0d exp=0/1", a0, t0);
    end
    total++; if (e0 !== 1'b0) begin bad++; $display("FAIL clr_en_q got=%b exp=0", e0); end
  endtask

  task automatic test_saturate_and_reset();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    ce = 1'b1;
    repeat (300) @(negedge clk);
    total++; if (a8 !== 8'd255) begin bad++; $display("FAIL sat_active8 got=%0d exp=255", a8); end
    total++; if (t8 !== 8'd255) begin bad++; $display("FAIL sat_total8 got=%0d exp=255", t8); end
    total++; if (a0 !== 32'd300) begin bad++; $display("FAIL sat_active0 got=%0d exp=300", a0); end
    total++; if (t0 !== 32'd300) begin bad++; $display("FAIL sat_total0 got=%0d exp=300", t0); end
    @(posedge clk);
    #1 total++; if (g8 !== 1'b1) begin bad++; $display("FAIL pre_rst_gclk got=%b exp=1", g8); end
    #1 rst_n = 1'b0;
    #1 total++; if (g8 !== 1'b0 || g0 !== 1'b0) begin
      bad++; $display("FAIL rst_gclk got=%b%b exp=00", g8, g0);
    end
    total++; if (a8 !== 8'd0 || t8 !== 8'd0 || e8 !== 1'b0 || a0 !== 32'd0) begin
      bad++; $display("FAIL rst_cnt got=%0d/%0d/%b/%0d exp=0/0/0/0", a8, t8, e8, a0);
    end
    @(negedge clk);
    ce = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 total++; if (g0 !== 1'b0) begin bad++; $display("FAIL rel_gclk_off got=%b exp=0", g0); end
    @(negedge clk);
    ce = 1'b1;
    @(posedge clk);
    #1 total++; if (g0 !== 1'b1) begin bad++; $display("FAIL rel_gclk_on got=%b exp=1", g0); end
    total++; if (g2 !== 1'b0) begin bad++; $display("FAIL rel_sync2_off got=%b exp=0", g2); end
  endtask

  initial begin
    rst_n   = 1'b0;
    ce      = 1'b0;
    test_en = 1'b0;
    cnt_clr = 1'b0;
    #12;
    test_reset();
    test_ce_window();
    test_glitch();
    test_sync2();
    test_scan();
    test_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
